// File: rtl/scr1_mem_pulp_obi.sv
// SCR1 core memory port to PULP/OBI bus bridge with an in-order request-tracking FIFO.
// Misaligned accesses can be answered locally with an error, without a bus transaction.
package scr1_memif_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_mem_pulp_obi
  import scr1_memif_pkg::*;
#(
  parameter int SCR1_ADDR_WIDTH   = 32,
  parameter int OUTSTANDING_DEPTH = 2,
  parameter bit MISALIGN_CHECK    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       core_req,
  output logic                       core_req_ack,
  input  type_scr1_mem_cmd_e         core_cmd,
  input  type_scr1_mem_width_e       core_width,
  input  logic [SCR1_ADDR_WIDTH-1:0] core_addr,
  input  logic [31:0]                core_wdata,
  output logic [31:0]                core_rdata,
  output type_scr1_mem_resp_e        core_resp,
  output logic                       data_req_o,
  input  logic                       data_gnt_i,
  output logic [SCR1_ADDR_WIDTH-1:0] data_addr_o,
  output logic                       data_we_o,
  output logic [3:0]                 data_be_o,
  output logic [31:0]                data_wdata_o,
  input  logic                       data_rvalid_i,
  input  logic [31:0]                data_rdata_i,
  input  logic                       data_err_i,
  output logic                       spurious_rvalid_o
);

  localparam int PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING_DEPTH);

  typedef struct packed {
    logic                 local_err;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [1:0]           off;
  } entry_t;

  function automatic logic [3:0] f_be(input type_scr1_mem_width_e width, input logic [1:0] off);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << off;
      SCR1_MEM_WIDTH_HWORD: return off[1] ? 4'hC : 4'h3;
      SCR1_MEM_WIDTH_WORD:  return 4'hF;
      default:              return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input type_scr1_mem_width_e width, input logic [31:0] wdata);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return {4{wdata[7:0]}};
      SCR1_MEM_WIDTH_HWORD: return {2{wdata[15:0]}};
      default:              return wdata;
    endcase
  endfunction

  function automatic logic [31:0] f_lane(input type_scr1_mem_width_e width, input logic [1:0] off,
                                         input logic [31:0] rdata);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return {24'h0, rdata[{off, 3'b000} +: 8]};
      SCR1_MEM_WIDTH_HWORD: return off[1] ? {16'h0, rdata[31:16]} : {16'h0, rdata[15:0]};
      SCR1_MEM_WIDTH_WORD:  return rdata;
      default:              return 32'h0;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  entry_t           r_fifo [OUTSTANDING_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_width_ok;
  logic   w_mis;
  logic   w_push;
  logic   w_pop;
  logic   w_spur;
  entry_t w_head;
  entry_t w_push_entry;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_width_ok = (core_width != SCR1_MEM_WIDTH_ERROR);
  assign w_mis      = MISALIGN_CHECK &&
                      (((core_width == SCR1_MEM_WIDTH_HWORD) && core_addr[0]) ||
                       ((core_width == SCR1_MEM_WIDTH_WORD) && (core_addr[1:0] != 2'b00)));

  // Request issue: the live request is gated by reset so nothing leaks out while held in reset
  assign data_req_o   = rst_n & core_req & ~w_full & ~w_mis & w_width_ok;
  assign core_req_ack = (data_req_o & data_gnt_i) | (rst_n & core_req & ~w_full & w_mis);
  assign data_addr_o  = {core_addr[SCR1_ADDR_WIDTH-1:2], 2'b00};
  assign data_we_o    = (core_cmd == SCR1_MEM_CMD_WR);
  assign data_be_o    = f_be(core_width, core_addr[1:0]);
  assign data_wdata_o = f_wdata(core_width, core_wdata);

  assign w_push       = core_req_ack;
  assign w_push_entry = '{local_err: w_mis, cmd: core_cmd, width: core_width, off: core_addr[1:0]};
  assign w_head       = r_fifo[r_rd_ptr];

  // Response side: combinational from the FIFO head, zero latency from rvalid
  always_comb begin
    core_resp  = SCR1_MEM_RESP_NOTRDY;
    core_rdata = 32'h0;
    w_pop      = 1'b0;
    w_spur     = 1'b0;
    if (w_empty) begin
      w_spur = data_rvalid_i;
    end else if (w_head.local_err) begin
      core_resp = SCR1_MEM_RESP_RDY_ER;
      w_pop     = 1'b1;
      w_spur    = data_rvalid_i;
    end else if (data_rvalid_i) begin
      w_pop     = 1'b1;
      core_resp = data_err_i ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      if (!data_err_i && (w_head.cmd == SCR1_MEM_CMD_RD))
        core_rdata = f_lane(w_head.width, w_head.off, data_rdata_i);
    end
  end

  assign spurious_rvalid_o = w_spur & rst_n;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_mem_pulp_obi.sv
// Bench for scr1_mem_pulp_obi: issue-path vector table, directed multi-cycle sequences,
// and randomized traffic checked against a queue-based model of the in-order bridge.
module tb_scr1_mem_pulp_obi;
  import scr1_memif_pkg::*;

  localparam int DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 core_req;
  logic                 core_req_ack;
  type_scr1_mem_cmd_e   core_cmd;
  type_scr1_mem_width_e core_width;
  logic [31:0]          core_addr;
  logic [31:0]          core_wdata;
  logic [31:0]          core_rdata;
  type_scr1_mem_resp_e  core_resp;
  logic                 data_req_o;
  logic                 data_gnt_i;
  logic [31:0]          data_addr_o;
  logic                 data_we_o;
  logic [3:0]           data_be_o;
  logic [31:0]          data_wdata_o;
  logic                 data_rvalid_i;
  logic [31:0]          data_rdata_i;
  logic                 data_err_i;
  logic                 spurious_rvalid_o;

  scr1_mem_pulp_obi #(.SCR1_ADDR_WIDTH(32), .OUTSTANDING_DEPTH(DEPTH), .MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_req_ack(core_req_ack), .core_cmd(core_cmd), .core_width(core_width),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata), .core_resp(core_resp),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .spurious_rvalid_o(spurious_rvalid_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req      = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0;
  endtask

  task automatic drive(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                       input logic [31:0] a, input logic [31:0] d, input logic g);
    core_req   = 1'b1;
    core_cmd   = c;
    core_width = w;
    core_addr  = a;
    core_wdata = d;
    data_gnt_i = g;
  endtask

  task automatic rsp(input logic [31:0] d, input logic e);
    data_rvalid_i = 1'b1;
    data_rdata_i  = d;
    data_err_i    = e;
  endtask

  typedef struct {
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e w;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic                 req;
    logic                 ack;
    logic [3:0]           be;
    logic [31:0]          wd;
  } vec_t;

  typedef struct {
    bit                   mis;
    bit                   rd;
    type_scr1_mem_width_e w;
    logic [1:0]           off;
  } ent_t;

  ent_t mq[$];

  function automatic logic [31:0] m_lane(input type_scr1_mem_width_e w, input logic [1:0] off,
                                         input logic [31:0] d);
    if (w == SCR1_MEM_WIDTH_BYTE)  return (d >> (8 * off)) & 32'hFF;
    if (w == SCR1_MEM_WIDTH_HWORD) return (d >> (8 * (off & 2'b10))) & 32'hFFFF;
    return d;
  endfunction

  function automatic logic [3:0] m_be(input type_scr1_mem_width_e w, input logic [1:0] off);
    if (w == SCR1_MEM_WIDTH_BYTE)  return 4'(1 << off);
    if (w == SCR1_MEM_WIDTH_HWORD) return 4'(3 << (off & 2'b10));
    if (w == SCR1_MEM_WIDTH_WORD)  return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] m_wd(input type_scr1_mem_width_e w, input logic [31:0] d);
    if (w == SCR1_MEM_WIDTH_BYTE)  return (d & 32'hFF) * 32'h0101_0101;
    if (w == SCR1_MEM_WIDTH_HWORD) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[9];
    tv[0] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h0000_1001, 32'h0000_005A, 1, 0, 4'h2, 32'h5A5A_5A5A};
    tv[1] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h0000_1002, 32'h1234_5677, 1, 0, 4'h4, 32'h7777_7777};
    tv[2] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h0000_2000, 32'hFFFF_1234, 1, 0, 4'h3, 32'h1234_1234};
    tv[3] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h0000_2002, 32'h0000_BEEF, 1, 0, 4'hC, 32'hBEEF_BEEF};
    tv[4] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0000_3000, 32'hCAFE_F00D, 1, 0, 4'hF, 32'hCAFE_F00D};
    tv[5] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h0000_2001, 32'h0000_0000, 0, 1, 4'h3, 32'h0000_0000};
    tv[6] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h0000_2003, 32'h1111_2222, 0, 1, 4'hF, 32'h1111_2222};
    tv[7] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0000_2002, 32'h0000_0000, 0, 1, 4'hF, 32'h0000_0000};
    tv[8] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, 32'h0000_4000, 32'h0000_0000, 0, 0, 4'h0, 32'h0000_0000};

    // Reset state, with core_req and rvalid active to show the outputs are held quiet
    idle();
    core_cmd   = SCR1_MEM_CMD_RD;
    core_width = SCR1_MEM_WIDTH_WORD;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    rst_n      = 1'b0;
    core_req   = 1'b1;
    data_gnt_i = 1'b1;
    data_rvalid_i = 1'b1;
    #3;
    chk("rst_req",  32'(data_req_o), 32'h0);
    chk("rst_ack",  32'(core_req_ack), 32'h0);
    chk("rst_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_spur", 32'(spurious_rvalid_o), 32'h0);
    idle();
    nxt(); nxt();
    rst_n = 1'b1;
    nxt();

    // Issue-path table, bus grant withheld so only local errors are accepted
    for (int i = 0; i < 9; i++) begin
      drive(tv[i].cmd, tv[i].w, tv[i].addr, tv[i].wdata, 1'b0);
      #3;
      chk($sformatf("tv%0d_req", i),  32'(data_req_o), 32'(tv[i].req));
      chk($sformatf("tv%0d_ack", i),  32'(core_req_ack), 32'(tv[i].ack));
      chk($sformatf("tv%0d_addr", i), data_addr_o, tv[i].addr & 32'hFFFF_FFFC);
      chk($sformatf("tv%0d_be", i),   32'(data_be_o), 32'(tv[i].be));
      chk($sformatf("tv%0d_we", i),   32'(data_we_o), 32'(tv[i].cmd == SCR1_MEM_CMD_WR));
      if (tv[i].w != SCR1_MEM_WIDTH_ERROR) chk($sformatf("tv%0d_wdata", i), data_wdata_o, tv[i].wd);
      nxt();
      core_req = 1'b0;
      #3;
      chk($sformatf("tv%0d_resp", i), 32'(core_resp),
          tv[i].ack ? 32'(SCR1_MEM_RESP_RDY_ER) : 32'(SCR1_MEM_RESP_NOTRDY));
      nxt();
    end

    // Plain word read, response one cycle after acceptance
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0, 1'b1);
    #3;
    chk("t1_ack", 32'(core_req_ack), 32'h1);
    chk("t1_addr", data_addr_o, 32'h100);
    chk("t1_be", 32'(data_be_o), 32'hF);
    chk("t1_resp0", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    nxt();
    idle();
    rsp(32'hDEAD_BEEF, 1'b0);
    #3;
    chk("t1_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t1_rdata", core_rdata, 32'hDEAD_BEEF);
    nxt();
    idle();

    // Byte read: lane chosen from the captured offset, not the live address
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h0, 1'b1);
    #3;
    chk("t2_be", 32'(data_be_o), 32'h8);
    chk("t2_ack", 32'(core_req_ack), 32'h1);
    nxt();
    idle();
    core_addr  = 32'h0;
    core_width = SCR1_MEM_WIDTH_WORD;
    rsp(32'h1122_3344, 1'b0);
    #3;
    chk("t2_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t2_rdata", core_rdata, 32'h0000_0011);
    nxt();
    idle();

    // Three back-to-back reads against a depth-2 tracker
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h200, 32'h0, 1'b1);
    #3; chk("t3_ack_a", 32'(core_req_ack), 32'h1);
    nxt();
    core_addr = 32'h204;
    #3; chk("t3_ack_b", 32'(core_req_ack), 32'h1);
    nxt();
    core_addr = 32'h208;
    rsp(32'h1, 1'b0);
    #3;
    chk("t3_ack_full", 32'(core_req_ack), 32'h0);
    chk("t3_req_full", 32'(data_req_o), 32'h0);
    chk("t3_rdata1", core_rdata, 32'h1);
    chk("t3_resp1", 32'(core_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    nxt();
    rsp(32'h2, 1'b0);
    #3;
    chk("t3_ack_c", 32'(core_req_ack), 32'h1);
    chk("t3_rdata2", core_rdata, 32'h2);
    nxt();
    core_req = 1'b0;
    rsp(32'h3, 1'b0);
    #3;
    chk("t3_rdata3", core_rdata, 32'h3);
    chk("t3_resp3", 32'(core_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    nxt();
    idle();
    #3; chk("t3_empty", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    nxt();

    // Misaligned word behind an outstanding read
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h300, 32'h0, 1'b1);
    #3; chk("t4_ack0", 32'(core_req_ack), 32'h1);
    nxt();
    core_addr = 32'h302;
    rsp(32'h55, 1'b0);
    #3;
    chk("t4_req_mis", 32'(data_req_o), 32'h0);
    chk("t4_ack_mis", 32'(core_req_ack), 32'h1);
    chk("t4_resp_ok", 32'(core_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t4_rdata_ok", core_rdata, 32'h55);
    nxt();
    idle();
    #3;
    chk("t4_resp_er", 32'(core_resp), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("t4_rdata_er", core_rdata, 32'h0);
    nxt();
    #3; chk("t4_empty", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    nxt();

    // Halfword store, bus reports an error
    drive(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h106, 32'h0000_ABCD, 1'b1);
    #3;
    chk("t5_addr", data_addr_o, 32'h104);
    chk("t5_be", 32'(data_be_o), 32'hC);
    chk("t5_wdata", data_wdata_o, 32'hABCD_ABCD);
    chk("t5_we", 32'(data_we_o), 32'h1);
    chk("t5_ack", 32'(core_req_ack), 32'h1);
    nxt();
    idle();
    rsp(32'h1234_5678, 1'b1);
    #3;
    chk("t5_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("t5_rdata", core_rdata, 32'h0);
    nxt();
    idle();

    // Reset with two reads in flight, then a late bus response
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h500, 32'h0, 1'b1);
    nxt();
    core_addr = 32'h504;
    nxt();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    #2 rst_n = 1'b1;
    nxt();
    rsp(32'hFEED_0001, 1'b0);
    #3;
    chk("t6_spur", 32'(spurious_rvalid_o), 32'h1);
    chk("t6_resp", 32'(core_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("t6_rdata", core_rdata, 32'h0);
    nxt();
    idle();
    #3; chk("t6_spur_clr", 32'(spurious_rvalid_o), 32'h0);
    nxt();

    // Randomized traffic against the queue model
    mq.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      int unsigned r;
      logic e_full, e_mis, e_req, e_ack, e_pop, e_spur;
      logic [31:0] e_rdata;
      type_scr1_mem_resp_e e_resp;
      ent_t ne;

      r = $urandom_range(0, 15);
      core_req   = ($urandom_range(0, 3) != 0);
      core_cmd   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
      core_width = (r == 0) ? SCR1_MEM_WIDTH_ERROR : type_scr1_mem_width_e'(r % 3);
      core_addr  = $urandom;
      core_wdata = $urandom;
      data_gnt_i = ($urandom_range(0, 9) < 7);
      data_rdata_i = $urandom;
      data_err_i   = ($urandom_range(0, 7) == 0);
      if (mq.size() == 0)  data_rvalid_i = ($urandom_range(0, 7) == 0);
      else if (!mq[0].mis) data_rvalid_i = $urandom_range(0, 1);
      else                 data_rvalid_i = 1'b0;

      e_full = (mq.size() == DEPTH);
      e_mis  = ((core_width == SCR1_MEM_WIDTH_HWORD) && (core_addr % 2 != 0)) ||
               ((core_width == SCR1_MEM_WIDTH_WORD) && (core_addr % 4 != 0));
      e_req  = core_req && !e_full && !e_mis && (core_width != SCR1_MEM_WIDTH_ERROR);
      e_ack  = (e_req && data_gnt_i) || (core_req && !e_full && e_mis);
      e_resp = SCR1_MEM_RESP_NOTRDY;
      e_rdata = 32'h0;
      e_pop  = 1'b0;
      e_spur = 1'b0;
      if (mq.size() == 0) begin
        e_spur = data_rvalid_i;
      end else if (mq[0].mis) begin
        e_resp = SCR1_MEM_RESP_RDY_ER;
        e_pop  = 1'b1;
      end else if (data_rvalid_i) begin
        e_pop  = 1'b1;
        e_resp = data_err_i ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        if (!data_err_i && mq[0].rd) e_rdata = m_lane(mq[0].w, mq[0].off, data_rdata_i);
      end

      #3;
      chk("rnd_req",   32'(data_req_o), 32'(e_req));
      chk("rnd_ack",   32'(core_req_ack), 32'(e_ack));
      chk("rnd_resp",  32'(core_resp), 32'(e_resp));
      chk("rnd_rdata", core_rdata, e_rdata);
      chk("rnd_spur",  32'(spurious_rvalid_o), 32'(e_spur));
      if (e_req) begin
        chk("rnd_addr",  data_addr_o, core_addr & 32'hFFFF_FFFC);
        chk("rnd_be",    32'(data_be_o), 32'(m_be(core_width, core_addr[1:0])));
        chk("rnd_wdata", data_wdata_o, m_wd(core_width, core_wdata));
        chk("rnd_we",    32'(data_we_o), 32'(core_cmd == SCR1_MEM_CMD_WR));
      end
      nxt();
      if (e_pop) void'(mq.pop_front());
      if (e_ack) begin
        ne.mis = e_mis;
        ne.rd  = (core_cmd == SCR1_MEM_CMD_RD);
        ne.w   = core_width;
        ne.off = core_addr[1:0];
        mq.push_back(ne);
      end
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
